mcs_io_master: RTL and testbench

- Hardware initiator for the MicroBlaze MCS IO bus. It is the CPU-side counterpart of the MCS-to-FPro bridge.
- Accepts single read/write requests over a valid/ready command interface.
- Issues each request as one MCS IO bus transaction (strobe, then wait for IO_ready), with a watchdog timeout.
- Returns read data or timeout status over a valid/ready response interface.
- Used to drive the bridge and the MMIO subsystem from non-CPU agents (debug/DMA front ends) and as a bus exerciser.

---
 rtl/mcs_io_pkg.sv | 20 ++
 rtl/mcs_io_watchdog.sv | 53 +++++
 rtl/mcs_io_master.sv | 198 +++++++++++++++++++
 tb/tb_mcs_io_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs_io_pkg.sv
// -----------------------------------------------------------------------------
// mcs_io_pkg
// Shared types and constants for the MCS IO bus initiator.
//   state_e      : transaction FSM states
//   READ_BE      : byte enables presented on the bus for every read
//   TIMEOUT_DATA : read data returned when the watchdog ends a transaction
// -----------------------------------------------------------------------------
package mcs_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0]  READ_BE      = 4'b1111;
  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage : mcs_io_pkg

// File: rtl/mcs_io_watchdog.sv
// -----------------------------------------------------------------------------
// mcs_io_watchdog
// Loadable up-counter with enable and terminal-count flag. It guards one bus
// transaction. Once the count reaches TIMEOUT_CYCLES-1 it stops, so it never
// wraps.
// Ports:
//   clk        : system clock (rising edge)
//   rst_n      : asynchronous active-low reset
//   load_i     : load load_val_i (has priority over en_i)
//   load_val_i : value to load
//   en_i       : count enable
//   tc_o       : count == TIMEOUT_CYCLES-1 (decoded from the count register)
// -----------------------------------------------------------------------------
module mcs_io_watchdog
  import mcs_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMR_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] ONE    = TMR_W'(1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  assign tc_o = (count_q == TC_VAL);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !tc_o) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : mcs_io_watchdog

// File: rtl/mcs_io_master.sv
// -----------------------------------------------------------------------------
// mcs_io_master
// MicroBlaze MCS IO bus initiator. It takes single read/write commands on a
// valid/ready request port and runs each one as one IO bus transaction
// (one-cycle strobe, then wait for IO_ready, with a watchdog). It returns the
// read data or the timeout status on a valid/ready response port.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready   : command handshake
//   req_wr, req_addr,
//   req_wr_data, req_be   : command fields (BE ignored for reads)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rd_data           : read data (0 for writes and timeouts)
//   rsp_timeout           : transaction ended by watchdog
//   IO_*                  : MCS IO bus initiator side
//   busy                  : FSM not idle
//   err_stray             : sticky, IO_ready seen with nothing outstanding
// All outputs are registers, so IO_ready has no combinational path to any
// output.
// -----------------------------------------------------------------------------
module mcs_io_master
  import mcs_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMR_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd_data,
  output logic        rsp_timeout,
  output logic        IO_addr_strobe,
  output logic        IO_read_strobe,
  output logic        IO_write_strobe,
  output logic [31:0] IO_address,
  output logic [3:0]  IO_byte_enable,
  output logic [31:0] IO_write_data,
  input  logic [31:0] IO_read_data,
  input  logic        IO_ready,
  output logic        busy,
  output logic        err_stray
);

  // The strobe cycle counts as the first elapsed cycle, so the watchdog is
  // loaded with 1. Then the terminal count (TIMEOUT_CYCLES-1) falls in the
  // last WAIT cycle and RESP starts exactly TIMEOUT_CYCLES cycles after the
  // strobe.
  localparam logic [TMR_W-1:0] WD_LOAD = TMR_W'(1);

  state_e      state_q;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        addr_strobe_q;
  logic        read_strobe_q;
  logic        write_strobe_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rd_data_q;
  logic        rsp_timeout_q;
  logic        busy_q;
  logic        err_stray_q;

  logic        wd_load;
  logic        wd_en;
  logic        wd_tc;

  assign wd_load = (state_q == STROBE);
  assign wd_en   = (state_q == WAIT);

  mcs_io_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .en_i       (wd_en),
    .tc_o       (wd_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      req_ready_q    <= 1'b0;
      addr_strobe_q  <= 1'b0;
      read_strobe_q  <= 1'b0;
      write_strobe_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rd_data_q  <= '0;
      rsp_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
      err_stray_q    <= 1'b0;
    end else begin
      // A ready with no transaction outstanding is only flagged. It never
      // affects state or response.
      if (IO_ready && ((state_q == IDLE) || (state_q == RESP))) begin
        err_stray_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          // req_ready comes up one cycle after reset release, so acceptance
          // uses the registered flag and not the state alone.
          if (req_valid && req_ready_q) begin
            state_q        <= STROBE;
            wr_q           <= req_wr;
            addr_q         <= req_addr;
            wdata_q        <= req_wr_data;
            be_q           <= req_wr ? req_be : READ_BE;
            addr_strobe_q  <= 1'b1;
            write_strobe_q <= req_wr;
            read_strobe_q  <= !req_wr;
            req_ready_q    <= 1'b0;
            busy_q         <= 1'b1;
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        STROBE: begin
          addr_strobe_q  <= 1'b0;
          write_strobe_q <= 1'b0;
          read_strobe_q  <= 1'b0;
          if (IO_ready) begin
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_rd_data_q <= wr_q ? '0 : IO_read_data;
          end else begin
            state_q <= WAIT;
          end
        end

        WAIT: begin
          // IO_ready is checked first so it wins over the terminal count.
          if (IO_ready) begin
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_rd_data_q <= wr_q ? '0 : IO_read_data;
          end else if (wd_tc) begin
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rd_data_q <= TIMEOUT_DATA;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state_q       <= IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_rd_data_q <= '0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            wr_q          <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rd_data     = rsp_rd_data_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign IO_addr_strobe  = addr_strobe_q;
  assign IO_read_strobe  = read_strobe_q;
  assign IO_write_strobe = write_strobe_q;
  assign IO_address      = addr_q;
  assign IO_byte_enable  = be_q;
  assign IO_write_data   = wdata_q;
  assign busy            = busy_q;
  assign err_stray       = err_stray_q;

endmodule : mcs_io_master

// File: tb/tb_mcs_io_master.sv
// -----------------------------------------------------------------------------
// tb_mcs_io_master
// Directed bench for mcs_io_master. The main DUT uses TIMEOUT_CYCLES=8. A
// second instance with TIMEOUT_CYCLES=4 has its own req_valid and covers the
// ready-at-terminal-count case.
// -----------------------------------------------------------------------------
module tb_mcs_io_master;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_valid4;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wr_data;
  logic [3:0]  req_be;
  logic        rsp_ready;
  logic [31:0] IO_read_data;
  logic        IO_ready;

  logic        req_ready, rsp_valid, rsp_timeout, busy, err_stray;
  logic [31:0] rsp_rd_data, IO_address, IO_write_data;
  logic [3:0]  IO_byte_enable;
  logic        IO_addr_strobe, IO_read_strobe, IO_write_strobe;

  logic        req_ready4, rsp_valid4, rsp_timeout4, busy4, err_stray4;
  logic [31:0] rsp_rd_data4, IO_address4, IO_write_data4;
  logic [3:0]  IO_byte_enable4;
  logic        IO_addr_strobe4, IO_read_strobe4, IO_write_strobe4;

  int total;
  int bad;

  mcs_io_master #(.TIMEOUT_CYCLES(8), .TMR_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data),
    .rsp_timeout(rsp_timeout),
    .IO_addr_strobe(IO_addr_strobe), .IO_read_strobe(IO_read_strobe),
    .IO_write_strobe(IO_write_strobe), .IO_address(IO_address),
    .IO_byte_enable(IO_byte_enable), .IO_write_data(IO_write_data),
    .IO_read_data(IO_read_data), .IO_ready(IO_ready),
    .busy(busy), .err_stray(err_stray)
  );

  mcs_io_master #(.TIMEOUT_CYCLES(4), .TMR_W(8)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_wr(req_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_be(req_be),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data4),
    .rsp_timeout(rsp_timeout4),
    .IO_addr_strobe(IO_addr_strobe4), .IO_read_strobe(IO_read_strobe4),
    .IO_write_strobe(IO_write_strobe4), .IO_address(IO_address4),
    .IO_byte_enable(IO_byte_enable4), .IO_write_data(IO_write_data4),
    .IO_read_data(IO_read_data), .IO_ready(IO_ready),
    .busy(busy4), .err_stray(err_stray4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%0b exp=0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if ({IO_addr_strobe, IO_read_strobe, IO_write_strobe} !== 3'b000) begin bad++; $display("FAIL rst_strobes got=%03b exp=000", {IO_addr_strobe, IO_read_strobe, IO_write_strobe}); end
    total++; if ({IO_address, IO_write_data, IO_byte_enable} !== 68'h0) begin bad++; $display("FAIL rst_io_bus got=%0h exp=0", {IO_address, IO_write_data, IO_byte_enable}); end
    total++; if ({busy, err_stray, rsp_timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%03b exp=000", {busy, err_stray, rsp_timeout}); end
    #20;
    reset_n = 1'b1;
    tick();
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%0b exp=1", req_ready); end
    $display("txn reset: req_ready=%0b busy=%0b", req_ready, busy);
  endtask

  task automatic test_write_imm();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'hC000_0104;
    req_wr_data = 32'h0000_A5A5; req_be = 4'b0011;
    tick();                                   // T+1: STROBE
    req_valid = 1'b0;
    total++; if ({IO_addr_strobe, IO_write_strobe, IO_read_strobe} !== 3'b110) begin bad++; $display("FAIL wr_strobes got=%03b exp=110", {IO_addr_strobe, IO_write_strobe, IO_read_strobe}); end
    total++; if (IO_address !== 32'hC000_0104) begin bad++; $display("FAIL wr_addr got=%h exp=c0000104", IO_address); end
    total++; if (IO_write_data !== 32'h0000_A5A5) begin bad++; $display("FAIL wr_data got=%h exp=0000a5a5", IO_write_data); end
    total++; if (IO_byte_enable !== 4'b0011) begin bad++; $display("FAIL wr_be got=%b exp=0011", IO_byte_enable); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wr_req_ready got=%0b exp=0", req_ready); end
    IO_ready = 1'b1;                          // combinational-ready responder
    tick();                                   // T+2: RESP
    IO_ready = 1'b0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_rsp_valid got=%0b exp=1", rsp_valid); end
    total++; if ({rsp_timeout, rsp_rd_data} !== 33'h0) begin bad++; $display("FAIL wr_rsp got=%0b/%h exp=0/0", rsp_timeout, rsp_rd_data); end
    total++; if ({IO_addr_strobe, IO_write_strobe} !== 2'b00) begin bad++; $display("FAIL wr_strobe_len got=%02b exp=00", {IO_addr_strobe, IO_write_strobe}); end
    rsp_ready = 1'b1;
    tick();                                   // back in IDLE
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL wr_done got=%02b exp=00", {rsp_valid, busy}); end
    total++; if (IO_address !== 32'h0) begin bad++; $display("FAIL wr_idle_addr got=%h exp=0", IO_address); end
    total++; if (err_stray !== 1'b0) begin bad++; $display("FAIL wr_err_stray got=%0b exp=0", err_stray); end
    $display("txn write addr=c0000104 data=0000a5a5 be=0011 immediate ready");
  endtask

  task automatic test_read_wait();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'hC000_0080;
    req_wr_data = 32'h1111_2222; req_be = 4'b0001;
    tick();                                   // S
    req_valid = 1'b0;
    total++; if ({IO_addr_strobe, IO_read_strobe, IO_write_strobe} !== 3'b110) begin bad++; $display("FAIL rd_strobes got=%03b exp=110", {IO_addr_strobe, IO_read_strobe, IO_write_strobe}); end
    total++; if (IO_byte_enable !== 4'hF) begin bad++; $display("FAIL rd_be got=%h exp=f", IO_byte_enable); end
    for (int k = 1; k <= 5; k++) begin
      tick();                                 // S+k
      total++; if ({IO_addr_strobe, IO_read_strobe, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rd_wait%0d got=%03b exp=000", k, {IO_addr_strobe, IO_read_strobe, rsp_valid}); end
      total++; if (IO_address !== 32'hC000_0080) begin bad++; $display("FAIL rd_hold%0d got=%h exp=c0000080", k, IO_address); end
    end
    IO_ready = 1'b1; IO_read_data = 32'h1234_5678;
    tick();                                   // S+6
    IO_ready = 1'b0; IO_read_data = 32'h0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got=%0b exp=1", rsp_valid); end
    total++; if (rsp_rd_data !== 32'h1234_5678) begin bad++; $display("FAIL rd_data got=%h exp=12345678", rsp_rd_data); end
    total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL rd_timeout got=%0b exp=0", rsp_timeout); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn read addr=c0000080 wait=5 data=%h", 32'h1234_5678);
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'hC000_0200;
    req_wr_data = 32'h0; req_be = 4'b0000;
    tick();                                   // S
    req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL to_early%0d got=%0b exp=0", k, rsp_valid); end
    end
    tick();                                   // S+8
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL to_rsp_valid got=%0b exp=1", rsp_valid); end
    total++; if (rsp_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%0b exp=1", rsp_timeout); end
    total++; if (rsp_rd_data !== 32'h0) begin bad++; $display("FAIL to_data got=%h exp=0", rsp_rd_data); end
    IO_ready = 1'b1; IO_read_data = 32'hDEAD_BEEF;   // stray, late ready
    tick();
    IO_ready = 1'b0; IO_read_data = 32'h0;
    total++; if (err_stray !== 1'b1) begin bad++; $display("FAIL to_err_stray got=%0b exp=1", err_stray); end
    total++; if ({rsp_valid, rsp_timeout, busy} !== 3'b111) begin bad++; $display("FAIL to_rsp_kept got=%03b exp=111", {rsp_valid, rsp_timeout, busy}); end
    total++; if (rsp_rd_data !== 32'h0) begin bad++; $display("FAIL to_data_kept got=%h exp=0", rsp_rd_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (err_stray !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%0b exp=1", err_stray); end
    $display("txn read addr=c0000200 timeout after 8 cycles, stray ready flagged");
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'hC000_0010;
    req_wr_data = 32'h0; req_be = 4'b0000;
    tick();                                   // STROBE of first
    // Second request stays pending while the first response is held.
    req_wr = 1'b1; req_addr = 32'hC000_0020; req_wr_data = 32'h5555_AAAA; req_be = 4'b1100;
    IO_ready = 1'b1; IO_read_data = 32'h0BAD_F00D;
    tick();                                   // RESP
    IO_ready = 1'b0; IO_read_data = 32'h0;
    for (int k = 0; k < 10; k++) begin
      total++; if ({rsp_valid, rsp_timeout, req_ready} !== 3'b100) begin bad++; $display("FAIL bp_flags%0d got=%03b exp=100", k, {rsp_valid, rsp_timeout, req_ready}); end
      total++; if (rsp_rd_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL bp_data%0d got=%h exp=0badf00d", k, rsp_rd_data); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();                                   // IDLE after handshake
    rsp_ready = 1'b0;
    total++; if ({req_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL bp_idle got=%02b exp=10", {req_ready, rsp_valid}); end
    tick();                                   // second request strobes
    req_valid = 1'b0;
    total++; if ({IO_addr_strobe, IO_write_strobe} !== 2'b11) begin bad++; $display("FAIL bp_second_strobe got=%02b exp=11", {IO_addr_strobe, IO_write_strobe}); end
    total++; if (IO_address !== 32'hC000_0020) begin bad++; $display("FAIL bp_second_addr got=%h exp=c0000020", IO_address); end
    IO_ready = 1'b1;
    tick();
    IO_ready = 1'b0;
    total++; if ({rsp_valid, rsp_timeout} !== 2'b10) begin bad++; $display("FAIL bp_second_rsp got=%02b exp=10", {rsp_valid, rsp_timeout}); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn read c0000010 held 10 cycles, then write c0000020 accepted");
  endtask

  task automatic test_coincide();
    // Ready in the terminal-count cycle wins over the watchdog.
    req_valid4 = 1'b1; req_wr = 1'b0; req_addr = 32'hC000_0300;
    req_wr_data = 32'h0; req_be = 4'b0000;
    tick();                                   // S
    req_valid4 = 1'b0;
    total++; if (IO_read_strobe4 !== 1'b1) begin bad++; $display("FAIL tc_strobe got=%0b exp=1", IO_read_strobe4); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (rsp_valid4 !== 1'b0) begin bad++; $display("FAIL tc_early%0d got=%0b exp=0", k, rsp_valid4); end
    end
    IO_ready = 1'b1; IO_read_data = 32'hCAFE_F00D;  // S+3 = terminal count
    tick();                                   // S+4
    IO_ready = 1'b0; IO_read_data = 32'h0;
    total++; if ({rsp_valid4, rsp_timeout4} !== 2'b10) begin bad++; $display("FAIL tc_rsp got=%02b exp=10", {rsp_valid4, rsp_timeout4}); end
    total++; if (rsp_rd_data4 !== 32'hCAFE_F00D) begin bad++; $display("FAIL tc_data got=%h exp=cafef00d", rsp_rd_data4); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn read c0000300 ready at terminal count data=cafef00d");

    // Same short watchdog, silent responder: timeout lands at S+4.
    tick();
    req_valid4 = 1'b1;
    tick();                                   // S
    req_valid4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (rsp_valid4 !== 1'b0) begin bad++; $display("FAIL tc4_early%0d got=%0b exp=0", k, rsp_valid4); end
    end
    tick();
    total++; if ({rsp_valid4, rsp_timeout4} !== 2'b11) begin bad++; $display("FAIL tc4_timeout got=%02b exp=11", {rsp_valid4, rsp_timeout4}); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn read c0000300 timeout after 4 cycles");
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'hC000_0400;
    req_wr_data = 32'h0; req_be = 4'b0000;
    tick();                                   // S
    req_valid = 1'b0;
    tick();
    tick();                                   // in WAIT
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    total++; if ({busy, err_stray, req_ready, rsp_valid} !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags got=%04b exp=0000", {busy, err_stray, req_ready, rsp_valid}); end
    total++; if ({IO_address, IO_byte_enable} !== 36'h0) begin bad++; $display("FAIL mid_rst_bus got=%h exp=0", {IO_address, IO_byte_enable}); end
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL mid_after%0d got=%02b exp=00", k, {rsp_valid, busy}); end
    end
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'hC000_0500;
    req_wr_data = 32'h0000_0042; req_be = 4'b1111;
    tick();
    req_valid = 1'b0;
    total++; if ({IO_addr_strobe, IO_write_strobe} !== 2'b11) begin bad++; $display("FAIL mid_new_strobe got=%02b exp=11", {IO_addr_strobe, IO_write_strobe}); end
    IO_ready = 1'b1;
    tick();
    IO_ready = 1'b0;
    total++; if ({rsp_valid, rsp_timeout, err_stray} !== 3'b100) begin bad++; $display("FAIL mid_new_rsp got=%03b exp=100", {rsp_valid, rsp_timeout, err_stray}); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("txn reset during wait, then write c0000500 completed");
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wr_data = '0; req_be = '0; rsp_ready = 1'b0;
    IO_read_data = '0; IO_ready = 1'b0;
    test_reset();
    test_write_imm();
    test_read_wait();
    test_timeout();
    test_back_to_back();
    test_coincide();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mcs_io_master
